// File: rtl/alu_logical_issue.sv
// Issue/decode front end and 2-stage pipe around the logical/shift unit.
// Optional ALU_LOGIC_FLAGS_EN adds registered out_zero/out_neg flags.
module alu_logical (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel2,
  input  logic        sel1,
  input  logic        sel0,
  output logic [31:0] y
);

  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    y = '0;
    unique case ({sel2, sel1, sel0})
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a ^ b;
      3'b110:  y = a << sh;
      3'b100:  y = $unsigned($signed(a) >>> sh);
      3'b101:  y = a >> sh;
      default: y = '0;
    endcase
  end

endmodule

module alu_logical_issue #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef ALU_LOGIC_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  typedef struct packed {
    logic [2:0]       sel;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } s1_t;

  s1_t         s1_q;
  s1_t         s1_d;
  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic [2:0]  dec_sel;
  logic        dec_ill;
  logic [31:0] alu_y;
  logic [31:0] res;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // opcode space is sparse; anything unlisted travels as an error packet
  always_comb begin
    dec_sel = 3'b000;
    dec_ill = 1'b0;
    unique case (1'b1)
      (in_op == 3'b000): dec_sel = 3'b000;
      (in_op == 3'b001): dec_sel = 3'b001;
      (in_op == 3'b010): dec_sel = 3'b010;
      (in_op == 3'b011): dec_sel = 3'b110;
      (in_op == 3'b100): dec_sel = 3'b100;
      (in_op == 3'b101): dec_sel = 3'b101;
      default:           dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    s1_d     = '0;
    s1_d.sel = dec_sel;
    s1_d.a   = in_a;
    s1_d.b   = in_b;
    s1_d.tag = in_tag;
    s1_d.ill = dec_ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_q     <= s1_d;
    end
  end

  alu_logical u_alu (
    .a    (s1_q.a),
    .b    (s1_q.b),
    .sel2 (s1_q.sel[2]),
    .sel1 (s1_q.sel[1]),
    .sel0 (s1_q.sel[0]),
    .y    (alu_y)
  );

  assign res = s1_q.ill ? 32'h0 : alu_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      out_data <= res;
      out_tag  <= s1_q.tag;
      out_err  <= s1_q.ill;
    end
  end

`ifdef ALU_LOGIC_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (s2_adv) begin
      out_zero <= (res == 32'h0);
      out_neg  <= res[31];
    end
  end
`endif

endmodule
